note_env_sched: RTL and testbench

Single-voice note scheduler and amplitude-envelope controller for the piano game.
- Arbitrates among the debounced piano keys and picks one owning note.
- Ramps the speaker amplitude pair (high/low) through attack, sustain and release toward the current volume level supplied by the volume controller.
- Sits between the key debouncers/volume control and the tone/audio DAC driver, which consumes note_idx and high/low.

---
 rtl/note_env_sched.sv | 139 +++++++++++++
 tb/tb_note_env_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_env_sched.sv
// Single-voice note scheduler with attack/sustain/release amplitude envelope.
// Picks the lowest-index held key as owner, ramps env toward the volume
// level on tick strobes, and drives the high/low speaker amplitude pair.
module note_env_sched #(
  parameter int unsigned NKEYS   = 8,
  parameter int unsigned STEP    = 330,
  parameter int unsigned MAXLV   = 99,
  parameter int unsigned ATK_INC = 5,
  parameter int unsigned REL_DEC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] key,
  input  logic [6:0]       vol_level,
  input  logic             tick,
  output logic [2:0]       note_idx,
  output logic             note_valid,
  output logic [6:0]       env,
  output logic [15:0]      high,
  output logic [15:0]      low,
  output logic [1:0]       state
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ATTACK  = 2'd1;
  localparam logic [1:0] ST_SUSTAIN = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [6:0] MAXLV7 = 7'(MAXLV);
  localparam logic [7:0] ATK8   = 8'(ATK_INC);
  localparam logic [6:0] REL7   = 7'(REL_DEC);

  logic [1:0] state_q, state_d;
  logic [6:0] env_q, env_d;
  logic [2:0] idx_q, idx_d;

  logic [6:0] vol_eff;
  logic [7:0] climb_sum;
  logic [6:0] climb;
  logic [6:0] fall;
  logic [2:0] win;
  logic       any_key;
  logic       owner_held;

  // Clamp the requested volume and precompute the climb/fall candidates.
  always_comb begin
    vol_eff   = (vol_level > MAXLV7) ? MAXLV7 : vol_level;
    climb_sum = {1'b0, env_q} + ATK8;
    climb     = (climb_sum >= {1'b0, vol_eff}) ? vol_eff : climb_sum[6:0];
    fall      = (env_q > REL7) ? (env_q - REL7) : 7'd0;
  end

  // Lowest-index held key wins; evaluated every cycle.
  always_comb begin
    win     = '0;
    any_key = 1'b0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      if (key[i] && !any_key) begin
        win     = 3'(i);
        any_key = 1'b1;
      end
    end
    owner_held = key[idx_q];
  end

  // Next-state and envelope update. The env rule always follows the current
  // (pre-transition) state, so transitions only override state/owner.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (any_key) begin
          state_d = ST_ATTACK;
          idx_d   = win;
        end
      end
      ST_ATTACK: begin
        if (tick) env_d = climb;
        if (!owner_held) begin
          if (any_key) begin
            state_d = ST_ATTACK;
            idx_d   = win;
          end else begin
            state_d = ST_RELEASE;
          end
        end else if (tick && (climb == vol_eff)) begin
          state_d = ST_SUSTAIN;
        end
      end
      ST_SUSTAIN: begin
        if (vol_eff < env_q)            env_d = vol_eff;
        else if (vol_eff > env_q && tick) env_d = climb;
        if (!owner_held) begin
          if (any_key) begin
            state_d = ST_ATTACK;
            idx_d   = win;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end
      default: begin
        if (tick) env_d = fall;
        if (any_key) begin
          state_d = ST_ATTACK;
          idx_d   = win;
        end else if (tick && (fall == 7'd0)) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      env_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs derived directly from the registered state.
  always_comb begin
    state      = state_q;
    env        = env_q;
    note_idx   = idx_q;
    note_valid = (state_q != ST_IDLE);
    high       = 16'(32'(env_q) * STEP);
    low        = 16'hFFFF - high;
  end

endmodule

// File: tb/tb_note_env_sched.sv
// Self-checking bench for note_env_sched: directed scenarios plus a
// randomized run checked against a behavioural envelope model.
module tb_note_env_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  key = '0;
  logic [6:0]  vol_level = '0;
  logic        tick = 1'b0;
  logic [2:0]  note_idx;
  logic        note_valid;
  logic [6:0]  env;
  logic [15:0] high;
  logic [15:0] low;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  note_env_sched #(.NKEYS(8), .STEP(330), .MAXLV(99), .ATK_INC(5), .REL_DEC(3)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .vol_level(vol_level), .tick(tick),
    .note_idx(note_idx), .note_valid(note_valid), .env(env),
    .high(high), .low(low), .state(state)
  );

  always #5 clk = ~clk;

  // Behavioural reference: phase names as ints, envelope as plain integers.
  localparam int P_IDLE = 0, P_ATK = 1, P_SUS = 2, P_REL = 3;
  int m_phase = P_IDLE;
  int m_env   = 0;
  int m_owner = 0;

  always @(posedge clk or negedge rst_n) begin
    int target, winner, nxt_env, nxt_phase, nxt_owner;
    if (!rst_n) begin
      m_phase = P_IDLE;
      m_env   = 0;
      m_owner = 0;
    end else begin
      target = (int'(vol_level) > 99) ? 99 : int'(vol_level);
      winner = -1;
      for (int i = 7; i >= 0; i--) if (key[i]) winner = i;
      nxt_env   = m_env;
      nxt_phase = m_phase;
      nxt_owner = m_owner;
      if (m_phase == P_IDLE) begin
        if (winner >= 0) begin nxt_phase = P_ATK; nxt_owner = winner; end
      end else if (m_phase == P_REL) begin
        if (tick) nxt_env = (m_env - 3 < 0) ? 0 : m_env - 3;
        if (winner >= 0) begin nxt_phase = P_ATK; nxt_owner = winner; end
        else if (tick && nxt_env == 0) nxt_phase = P_IDLE;
      end else begin
        if (m_phase == P_ATK) begin
          if (tick) nxt_env = (m_env + 5 > target) ? target : m_env + 5;
        end else begin
          if (target < m_env) nxt_env = target;
          else if (tick) nxt_env = (m_env + 5 > target) ? target : m_env + 5;
        end
        if (!key[m_owner]) begin
          if (winner >= 0) begin nxt_phase = P_ATK; nxt_owner = winner; end
          else nxt_phase = P_REL;
        end else if (m_phase == P_ATK && tick && nxt_env == target) begin
          nxt_phase = P_SUS;
        end
      end
      m_env   = nxt_env;
      m_phase = nxt_phase;
      m_owner = nxt_owner;
    end
  end

  // Inputs change at negedge; one clock edge happens; outputs sampled at next negedge.
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key = '0;
    tick = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state !== 2'd0 || env !== 7'd0 || note_idx !== 3'd0 || note_valid !== 1'b0 ||
        high !== 16'h0000 || low !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset: state=%0d env=%0d idx=%0d valid=%0b high=%0d low=%0d, want 0 0 0 0 0 65535",
               state, env, note_idx, note_valid, high, low);
    end
  endtask

  task automatic test_attack_sustain();
    int exp_env [6] = '{5, 10, 15, 20, 20, 20};
    int exp_st  [6] = '{1, 1, 1, 2, 2, 2};
    vol_level = 7'd20;
    key = 8'b0000_0100;
    cyc(1'b0);
    checks++;
    if (state !== 2'd1 || note_idx !== 3'd2 || note_valid !== 1'b1 || env !== 7'd0) begin
      errors++;
      $display("FAIL attack_start: state=%0d idx=%0d valid=%0b env=%0d, want 1 2 1 0",
               state, note_idx, note_valid, env);
    end
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1);
      checks++;
      if (int'(env) != exp_env[k] || int'(state) != exp_st[k]) begin
        errors++;
        $display("FAIL attack_tick%0d: env=%0d state=%0d, want %0d %0d", k + 1, env, state, exp_env[k], exp_st[k]);
      end
    end
    checks++;
    if (high !== 16'd6600 || low !== 16'd58935) begin
      errors++;
      $display("FAIL sustain_amp: high=%0d low=%0d, want 6600 58935", high, low);
    end
  endtask

  task automatic test_release();
    int exp_env [7] = '{17, 14, 11, 8, 5, 2, 0};
    key = '0;
    cyc(1'b0);
    checks++;
    if (state !== 2'd3 || env !== 7'd20 || note_idx !== 3'd2) begin
      errors++;
      $display("FAIL release_enter: state=%0d env=%0d idx=%0d, want 3 20 2", state, env, note_idx);
    end
    for (int k = 0; k < 7; k++) begin
      cyc(1'b1);
      checks++;
      if (int'(env) != exp_env[k] || (k < 6 && state !== 2'd3)) begin
        errors++;
        $display("FAIL release_tick%0d: env=%0d state=%0d, want %0d", k + 1, env, state, exp_env[k]);
      end
    end
    checks++;
    if (state !== 2'd0 || note_valid !== 1'b0 || high !== 16'd0 || low !== 16'hFFFF) begin
      errors++;
      $display("FAIL release_idle: state=%0d valid=%0b high=%0d low=%0d, want 0 0 0 65535",
               state, note_valid, high, low);
    end
  endtask

  task automatic test_arbitration();
    vol_level = 7'd20;
    key = 8'b0010_0010;
    cyc(1'b0);
    checks++;
    if (state !== 2'd1 || note_idx !== 3'd1) begin
      errors++;
      $display("FAIL arb_lowest: state=%0d idx=%0d, want 1 1", state, note_idx);
    end
    cyc(1'b1);
    key = 8'b0010_0011;
    cyc(1'b0);
    checks++;
    if (note_idx !== 3'd1 || state !== 2'd1 || env !== 7'd5) begin
      errors++;
      $display("FAIL arb_no_preempt: idx=%0d state=%0d env=%0d, want 1 1 5", note_idx, state, env);
    end
    key = 8'b0010_0001;
    cyc(1'b0);
    checks++;
    if (note_idx !== 3'd0 || state !== 2'd1 || env !== 7'd5) begin
      errors++;
      $display("FAIL arb_legato: idx=%0d state=%0d env=%0d, want 0 1 5", note_idx, state, env);
    end
  endtask

  task automatic test_vol_track();
    int exp_env [4] = '{17, 22, 27, 30};
    do_reset();
    vol_level = 7'd40;
    key = 8'b0000_1000;
    cyc(1'b0);
    repeat (8) cyc(1'b1);
    checks++;
    if (env !== 7'd40 || state !== 2'd2) begin
      errors++;
      $display("FAIL vol_reach40: env=%0d state=%0d, want 40 2", env, state);
    end
    vol_level = 7'd12;
    cyc(1'b0);
    checks++;
    if (env !== 7'd12 || high !== 16'd3960 || state !== 2'd2) begin
      errors++;
      $display("FAIL vol_snap: env=%0d high=%0d state=%0d, want 12 3960 2", env, high, state);
    end
    vol_level = 7'd30;
    cyc(1'b0);
    checks++;
    if (env !== 7'd12) begin
      errors++;
      $display("FAIL vol_no_tick_climb: env=%0d, want 12", env);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1);
      checks++;
      if (int'(env) != exp_env[k]) begin
        errors++;
        $display("FAIL vol_climb%0d: env=%0d, want %0d", k + 1, env, exp_env[k]);
      end
    end
  endtask

  task automatic test_release_retrigger();
    key = '0;
    cyc(1'b0);
    repeat (7) cyc(1'b1);
    checks++;
    if (env !== 7'd9 || state !== 2'd3) begin
      errors++;
      $display("FAIL retrig_pre: env=%0d state=%0d, want 9 3", env, state);
    end
    key = 8'b1000_0000;
    cyc(1'b1);
    checks++;
    if (state !== 2'd1 || note_idx !== 3'd7 || env !== 7'd6) begin
      errors++;
      $display("FAIL retrig: state=%0d idx=%0d env=%0d, want 1 7 6", state, note_idx, env);
    end
    vol_level = 7'd120;
    repeat (25) cyc(1'b1);
    checks++;
    if (env !== 7'd99 || high !== 16'd32670 || low !== 16'd32865 || state !== 2'd2) begin
      errors++;
      $display("FAIL saturate: env=%0d high=%0d low=%0d state=%0d, want 99 32670 32865 2",
               env, high, low, state);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    vol_level = 7'd50;
    key = 8'b0000_1000;
    cyc(1'b0);
    repeat (3) cyc(1'b1);
    checks++;
    if (env !== 7'd15 || state !== 2'd1) begin
      errors++;
      $display("FAIL areset_pre: env=%0d state=%0d, want 15 1", env, state);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (env !== 7'd0 || high !== 16'd0 || low !== 16'hFFFF || state !== 2'd0 || note_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset: env=%0d high=%0d low=%0d state=%0d valid=%0b, want 0 0 65535 0 0",
               env, high, low, state, note_valid);
    end
    @(negedge clk);
    key = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: key = '0;
          1: key = 8'(1 << $urandom_range(0, 7));
          default: key = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 19) == 0) vol_level = 7'($urandom_range(0, 127));
      cyc($urandom_range(0, 2) == 0);
      checks++;
      if (int'(state) != m_phase || int'(env) != m_env || int'(note_idx) != m_owner ||
          note_valid !== (m_phase != P_IDLE) || int'(high) != m_env * 330 ||
          int'(low) != 65535 - m_env * 330) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random c%0d: state=%0d env=%0d idx=%0d valid=%0b high=%0d, want %0d %0d %0d",
                   c, state, env, note_idx, note_valid, high, m_phase, m_env, m_owner);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_attack_sustain();
    test_release();
    test_arbitration();
    test_vol_track();
    test_release_retrigger();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
